// File: rtl/buffer_pkg.sv
// Shared types and helpers for the multi-bank buffer: FSM state encoding and
// the bank-select width calculation used on the port list.
package buffer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // A single bank still needs a 1-bit select port.
    function automatic int bank_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/buffer_bank.sv
// One storage bank: a single write port and one registered read port.
// The array carries no reset; the top level zeroes it with a clear sweep.
module buffer_bank #(
    parameter int ADDR_WIDTH = 10,
    parameter int WORD_NUM   = 2**10,
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wa,
    input  logic [WORD_WIDTH-1:0] wd,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] ra,
    output logic [WORD_WIDTH-1:0] q
);

    logic [WORD_WIDTH-1:0] mem [WORD_NUM];

    // NOTE: no reset branch here on purpose -- a reset term on a RAM array
    // prevents block-RAM inference; the owner clears contents by sweeping.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
        if (re) begin
            q <= mem[ra];
        end
    end

endmodule

// File: rtl/buffer_mb.sv
// Multi-bank buffer with registered write pipeline, registered reads and a
// hardware clear sweep. Define BUFFER_MB_BYPASS_EN to forward a pending write.
module buffer_mb
    import buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int WORD_NUM   = 2**10,
    parameter int WORD_WIDTH = 8,
    parameter int BANK_NUM   = 4,
    localparam int BANK_W    = bank_w(BANK_NUM)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [BANK_W-1:0]     wbank,
    input  logic [ADDR_WIDTH-1:0] wa,
    input  logic [WORD_WIDTH-1:0] wd,
    input  logic                  re,
    input  logic [BANK_W-1:0]     rbank,
    input  logic [ADDR_WIDTH-1:0] ra,
    output logic [WORD_WIDTH-1:0] q,
    output logic                  rvalid,
    input  logic                  clr,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_NUM - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_cnt;

    logic                  wr_valid_r;
    logic [BANK_W-1:0]     wbank_r;
    logic [ADDR_WIDTH-1:0] wa_r;
    logic [WORD_WIDTH-1:0] wd_r;

    logic                  rd_zero_r;
    logic [BANK_W-1:0]     rbank_r;
    logic [WORD_WIDTH-1:0] q_sel;

    logic                  w_ok;
    logic                  r_ok;
    logic                  idle;

    assign idle = (state == ST_IDLE);
    assign w_ok = (int'(wbank) < BANK_NUM) && (int'(wa) < WORD_NUM);
    assign r_ok = (int'(rbank) < BANK_NUM) && (int'(ra) < WORD_NUM);

    // NOTE: every clocked block uses non-blocking assignments so all flops
    // update from the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clr) begin
                        state   <= ST_CLEAR;
                        busy    <= 1'b1;
                        clr_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt == LAST_ADDR) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // A write sampled alongside an accepted clr is dropped; the one already
    // in the pipeline register still commits on this edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_valid_r <= 1'b0;
            wbank_r    <= '0;
            wa_r       <= '0;
            wd_r       <= '0;
        end else begin
            wr_valid_r <= we && w_ok && idle && !clr;
            wbank_r    <= wbank;
            wa_r       <= wa;
            wd_r       <= wd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid    <= 1'b0;
            rd_zero_r <= 1'b1;
            rbank_r   <= '0;
        end else begin
            rvalid    <= re;
            rd_zero_r <= !(re && r_ok && idle);
            rbank_r   <= rbank;
        end
    end

    logic [WORD_WIDTH-1:0] bank_q [BANK_NUM];
    logic [ADDR_WIDTH-1:0] mem_wa;
    logic [WORD_WIDTH-1:0] mem_wd;

    assign mem_wa = idle ? wa_r : clr_cnt;
    assign mem_wd = idle ? wd_r : '0;

    for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
        logic bank_we;
        logic bank_re;

        assign bank_we = !idle || (wr_valid_r && (wbank_r == BANK_W'(b)));
        assign bank_re = re && r_ok && idle && (rbank == BANK_W'(b));

        buffer_bank #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .WORD_NUM   (WORD_NUM),
            .WORD_WIDTH (WORD_WIDTH)
        ) u_bank (
            .clk (clk),
            .we  (bank_we),
            .wa  (mem_wa),
            .wd  (mem_wd),
            .re  (bank_re),
            .ra  (ra),
            .q   (bank_q[b])
        );
    end

    // NOTE: default assignment first so the loop cannot leave q_sel unassigned
    // on any path, which would otherwise infer a latch.
    always_comb begin
        q_sel = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            if (rbank_r == BANK_W'(b)) begin
                q_sel = bank_q[b];
            end
        end
    end

`ifdef BUFFER_MB_BYPASS_EN
    logic                  byp_hit_r;
    logic [WORD_WIDTH-1:0] byp_data_r;

    // The pending write commits on the same edge the read samples the array,
    // so a matching read takes the pipeline data instead.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byp_hit_r  <= 1'b0;
            byp_data_r <= '0;
        end else begin
            byp_hit_r  <= re && wr_valid_r && (rbank == wbank_r) && (ra == wa_r);
            byp_data_r <= wd_r;
        end
    end

    assign q = rd_zero_r ? '0 : (byp_hit_r ? byp_data_r : q_sel);
`else
    assign q = rd_zero_r ? '0 : q_sel;
`endif

endmodule

// File: tb/tb_buffer_mb.sv
// Scoreboard bench for buffer_mb: a 4-bank default instance and a 3-bank,
// 1000-word instance share stimulus; a monitor checks every rvalid beat.
module tb_buffer_mb;

    logic       clk;
    logic       reset_n;
    logic       we;
    logic [1:0] wbank;
    logic [9:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [1:0] rbank;
    logic [9:0] ra;
    logic       clr;

    logic [7:0] q,  q3;
    logic       rvalid, rvalid3;
    logic       busy, busy3;
    logic       done, done3;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      name;
        logic [7:0] q_main;
        logic [7:0] q_b3;
    } exp_t;

    exp_t sb [$];

    buffer_mb dut (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (we),
        .wbank   (wbank),
        .wa      (wa),
        .wd      (wd),
        .re      (re),
        .rbank   (rbank),
        .ra      (ra),
        .q       (q),
        .rvalid  (rvalid),
        .clr     (clr),
        .busy    (busy),
        .done    (done)
    );

    buffer_mb #(
        .ADDR_WIDTH (10),
        .WORD_NUM   (1000),
        .WORD_WIDTH (8),
        .BANK_NUM   (3)
    ) dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (we),
        .wbank   (wbank),
        .wa      (wa),
        .wd      (wd),
        .re      (re),
        .rbank   (rbank),
        .ra      (ra),
        .q       (q3),
        .rvalid  (rvalid3),
        .clr     (clr),
        .busy    (busy3),
        .done    (done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] b, input logic [9:0] a, input logic [7:0] d);
        we = 1'b1; wbank = b; wa = a; wd = d;
        tick();
        we = 1'b0;
    endtask

    task automatic do_read(input string nm, input logic [1:0] b, input logic [9:0] a,
                           input logic [7:0] e_main, input logic [7:0] e_b3);
        re = 1'b1; rbank = b; ra = a;
        sb.push_back('{nm, e_main, e_b3});
        tick();
        re = 1'b0;
    endtask

    // Counts negedges with busy=1 from now, then checks the done pulse.
    task automatic wait_sweep(input string nm, input int exp_len, input bit chk_len);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 5000) begin
            n++;
            @(negedge clk);
        end
        if (chk_len) check({nm, "_len"}, n, exp_len);
        check({nm, "_done"}, done, 1);
        @(negedge clk);
        check({nm, "_done_pulse"}, done, 0);
        check({nm, "_idle"}, busy, 0);
    endtask

    // Monitor: every read beat is matched against the next scoreboard entry.
    always @(negedge clk) begin
        if (rvalid) begin
            if (sb.size() == 0) begin
                check("unexpected_rvalid", rvalid, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_q"},       q,       e.q_main);
                check({e.name, "_q_b3"},    q3,      e.q_b3);
                check({e.name, "_rvalid3"}, rvalid3, 1);
            end
        end else if (rvalid3) begin
            check("rvalid3_alone", rvalid3, 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        we = 1'b0; wbank = '0; wa = '0; wd = '0;
        re = 1'b0; rbank = '0; ra = '0; clr = 1'b0;
        tick();
        tick();
        check("rst_busy",   busy,   1);
        check("rst_rvalid", rvalid, 0);
        check("rst_done",   done,   0);
        check("rst_q",      q,      0);

        reset_n = 1'b1;
        wait_sweep("init_sweep", 1024, 1'b1);
        check("init_b3_idle", busy3, 0);
        do_read("rd_b3_a1023", 2'd3, 10'd1023, 8'h00, 8'h00);

        // Write latency: read two cycles after the write sees new data.
        do_write(2'd1, 10'd5, 8'hA5);
        tick();
        do_read("rd_b1_a5", 2'd1, 10'd5, 8'hA5, 8'hA5);
        do_read("rd_b0_a5", 2'd0, 10'd5, 8'h00, 8'h00);

        // Same-cycle read and write return the old content.
        we = 1'b1; wbank = 2'd2; wa = 10'd8; wd = 8'h11;
        do_read("rd_same_cycle", 2'd2, 10'd8, 8'h00, 8'h00);
        we = 1'b0;
        tick();
        do_read("rd_b2_a8", 2'd2, 10'd8, 8'h11, 8'h11);

        // Read one cycle after the write: forwarding decides the result.
        do_write(2'd0, 10'd7, 8'h3C);
`ifdef BUFFER_MB_BYPASS_EN
        do_read("rd_next_cycle", 2'd0, 10'd7, 8'h3C, 8'h3C);
`else
        do_read("rd_next_cycle", 2'd0, 10'd7, 8'h00, 8'h00);
`endif
        do_read("rd_b0_a7", 2'd0, 10'd7, 8'h3C, 8'h3C);

        // Out-of-range bank (3-bank instance) and address (1000-word instance).
        do_write(2'd3, 10'd20, 8'h77);
        do_write(2'd0, 10'd1010, 8'h5A);
        tick();
        do_read("rd_b3_a20",   2'd3, 10'd20,   8'h77, 8'h00);
        do_read("rd_b0_a1010", 2'd0, 10'd1010, 8'h5A, 8'h00);

        for (int b = 0; b < 4; b++) do_write(2'(b), 10'd9, 8'hFF);
        tick();
        do_read("rd_fill_b2", 2'd2, 10'd9, 8'hFF, 8'hFF);
        do_read("rd_fill_b3", 2'd3, 10'd9, 8'hFF, 8'h00);

        // Clear sweep with a write in the clr cycle and another during busy.
        clr = 1'b1; we = 1'b1; wbank = 2'd1; wa = 10'd1023; wd = 8'h66;
        tick();
        clr = 1'b0; we = 1'b0;
        check("clr_busy", busy, 1);
        do_read("rd_during_busy", 2'd2, 10'd9, 8'h00, 8'h00);
        repeat (100) tick();
        clr = 1'b1;
        do_write(2'd0, 10'd9, 8'h55);
        clr = 1'b0;
        wait_sweep("clr_sweep", 0, 1'b0);
        for (int b = 0; b < 4; b++) do_read("rd_clr_a9", 2'(b), 10'd9, 8'h00, 8'h00);
        do_read("rd_clr_b1_a5", 2'd1, 10'd5,    8'h00, 8'h00);
        do_read("rd_clr_a1023", 2'd1, 10'd1023, 8'h00, 8'h00);
        tick();
        tick();

        // Reset in the middle of the post-reset sweep restarts it from 0.
        reset_n = 1'b0;
        #1;
        check("rst2_busy",   busy,   1);
        check("rst2_rvalid", rvalid, 0);
        tick();
        reset_n = 1'b1;
        repeat (300) @(negedge clk);
        check("mid_sweep_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("rst3_busy", busy, 1);
        check("rst3_done", done, 0);
        check("rst3_q",    q,    0);
        tick();
        tick();
        reset_n = 1'b1;
        wait_sweep("restart_sweep", 1024, 1'b1);
        do_read("rd_post_b0_a7",  2'd0, 10'd7,  8'h00, 8'h00);
        do_read("rd_post_b3_a20", 2'd3, 10'd20, 8'h00, 8'h00);

        tick();
        tick();
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/buffer_mb.md
BUFFER_MB -- requirements
Module: buffer_mb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning word address width per bank.
REQ-002 SHALL have parameter WORD_NUM, default 2**10, meaning words per bank (at most 2**ADDR_WIDTH).
REQ-003 SHALL have parameter WORD_WIDTH, default 8, meaning data width in bits.
REQ-004 SHALL have parameter BANK_NUM, default 4, meaning number of independent banks (at least 1).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have ports we (input, 1), wbank (input, BANK_W=max(1,$clog2(BANK_NUM))), wa (input, ADDR_WIDTH) and wd (input, WORD_WIDTH): write request, target bank, address and data.
REQ-008 SHALL have ports re (input, 1), rbank (input, BANK_W) and ra (input, ADDR_WIDTH): read request, bank and address.
REQ-009 SHALL have ports q (output, WORD_WIDTH) and rvalid (output, 1): read data and its qualifier.
REQ-010 SHALL have ports clr (input, 1), busy (output, 1) and done (output, 1): clear request, clear in progress, and a one-cycle clear-complete pulse.

Function
REQ-011 Write path SHALL register we/wbank/wa/wd at edge N and commit mem[wbank][wa] at edge N+1, giving write latency 2 edges.
REQ-012 Read path SHALL register the read at edge N; q and rvalid are valid after edge N and hold until the next edge; rvalid=re delayed by 1.
REQ-013 A read in the same cycle as a write to the same location SHALL return the old data.
REQ-014 A read issued one cycle after a write to the same location SHALL follow REQ-029 / REQ-030.
REQ-015 The FSM SHALL have states IDLE and CLEAR: IDLE->CLEAR when clr=1, IDLE->CLEAR on reset release, and CLEAR->IDLE after clearing address WORD_NUM-1.
REQ-016 In CLEAR, a counter SHALL step 0..WORD_NUM-1 by one per cycle, writing 0 to that address in every bank, so the sweep lasts WORD_NUM cycles.
REQ-017 busy SHALL be 1 exactly while the state is CLEAR.
REQ-018 done SHALL be 1 for the single cycle after the last clear write.
REQ-019 While busy=1, we SHALL be ignored: nothing is registered or committed.
REQ-020 In the cycle clr is accepted, the write sampled that cycle SHALL be discarded, and a write registered in the preceding cycle SHALL still commit.
REQ-021 While busy=1, re SHALL still produce rvalid=1 with q=0.
REQ-022 clr asserted while busy=1 SHALL be ignored; the sweep does not restart.
REQ-023 Requests with bank index >= BANK_NUM or address >= WORD_NUM SHALL be dropped for writes and return q=0 for reads, with rvalid still asserted.

Reset
REQ-024 While reset_n=0: state=CLEAR, counter=0, the write pipeline register is invalid, q=0, rvalid=0 and done=0.
REQ-025 busy SHALL read 1 from reset assertion until the post-reset sweep completes, so memory is zero after WORD_NUM cycles.
REQ-026 Memory arrays SHALL have no reset term; zeroing is by the sweep only.
REQ-027 Reset asserted mid-sweep SHALL restart the sweep from address 0 on release.

Configuration
REQ-028 Macro BUFFER_MB_BYPASS_EN SHALL select write-to-read forwarding.
REQ-029 With BUFFER_MB_BYPASS_EN defined: a read matching the pending registered write (same bank and address, issued one cycle after the write) SHALL return the new wd.
REQ-030 Without BUFFER_MB_BYPASS_EN: that read SHALL return the old content, and no compare logic is built.

Structure
REQ-031 Package buffer_pkg SHALL hold the FSM state enum (ST_IDLE, ST_CLEAR) and a bank-index width helper function.
REQ-032 Sub-module buffer_bank SHALL implement one bank: one registered read port and one write port, no reset on the array. buffer_mb instantiates BANK_NUM copies and muxes q by the registered rbank.

Verification
REQ-033 Release reset -> busy=1 for exactly 1024 cycles, then done=1 for 1 cycle; reading bank 3, address 1023 then gives q=0.
REQ-034 Write bank 1, address 5, 8'hA5, then read bank 1, address 5 two cycles later -> q=8'hA5, rvalid=1; bank 0, address 5 still reads 0.
REQ-035 Write address 7 with 8'h3C, then read it the next cycle -> q=8'h3C with the bypass macro, old value 8'h00 without it.
REQ-036 Fill address 9 in all banks with 8'hFF, pulse clr, issue we during busy -> all reads after done return 0, the dropped write is absent, and re during busy gives q=0 with rvalid=1.
REQ-037 Assert reset_n=0 at sweep count 300 -> the sweep restarts at 0 and busy lasts a further 1024 cycles.
REQ-038 Use BANK_NUM=3 and write or read bank 3 -> the write is dropped and the read gives q=0, rvalid=1.
